// File: rtl/decode_stage.sv
// decode_stage -- RV32I decode pipeline register.
//
// Takes one instruction word per transfer from fetch, decodes it into ALU
// controls, register addresses, immediate and class flags, and holds the
// result in a single output register for execute. Latency is one cycle; a
// pop and a push in the same cycle keep one instruction per cycle flowing.
//
// Handshake (both sides): a beat moves when valid && ready on the same
// rising edge. The producer holds valid and payload stable until the beat
// moves; ready never depends on the producer's valid. Here
// in_ready = !rst && (!out_valid || out_ready), and every output stays frozen
// while out_valid && !out_ready.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_instr, in_pc          instruction word and its PC
//   flush                    drops held and incoming instruction
//   out_valid/out_ready      downstream handshake
//   alu_mode, eval_mode, sign_ext, src1_pc, src2_imm   ALU controls
//   rs1_addr, rs2_addr, rd_addr, rd_wen, imm, pc_out   operands
//   is_branch, is_jal, is_jalr, is_load, is_store, is_slt, mem_size, mem_unsigned
//   ill_instr                only when DECODE_ILLEGAL_EN is defined
//
// Configuration macro: DECODE_ILLEGAL_EN adds the registered ill_instr flag.
// Illegal encodings decode as NOP in both builds.
//
// ALU/EVAL codes mirror defines.v:
//   ALU_ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7
//   EVAL_EQ=0 NEQ=1 LT=2 GE=3
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  alu_mode,
   output logic [1:0]  eval_mode,
   output logic        sign_ext,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [4:0]  rd_addr,
   output logic        rd_wen,
   output logic [31:0] imm,
   output logic [31:0] pc_out,
   output logic        src1_pc,
   output logic        src2_imm,
   output logic        is_branch,
   output logic        is_jal,
   output logic        is_jalr,
   output logic        is_load,
   output logic        is_store,
   output logic        is_slt,
   output logic [1:0]  mem_size,
`ifdef DECODE_ILLEGAL_EN
   output logic        ill_instr,
`endif
   output logic        mem_unsigned
);

   localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                          ALU_XOR = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_SRA = 3'd7;
   localparam logic [1:0] EVAL_EQ = 2'd0, EVAL_NEQ = 2'd1, EVAL_LT = 2'd2, EVAL_GE = 2'd3;

   localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111,
                          OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                          OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                          OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

   // All-zero is a NOP with pc 0, so reset is simply '0.
   typedef struct packed {
      logic [2:0]  alu_mode;
      logic [1:0]  eval_mode;
      logic        sign_ext;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        rd_wen;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        src1_pc;
      logic        src2_imm;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        is_load;
      logic        is_store;
      logic        is_slt;
      logic [1:0]  mem_size;
      logic        mem_unsigned;
`ifdef DECODE_ILLEGAL_EN
      logic        ill;
`endif
   } dec_t;

   dec_t dec;
   dec_t q;
   logic q_valid;
   logic ill;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   assign in_ready = !rst && (!q_valid || out_ready);

   always_comb begin
      dec              = '0;
      ill              = 1'b0;
      dec.alu_mode     = ALU_ADD;
      dec.eval_mode    = EVAL_EQ;
      dec.rs1_addr     = in_instr[19:15];
      dec.rs2_addr     = in_instr[24:20];
      dec.rd_addr      = in_instr[11:7];
      dec.pc           = in_pc;
      dec.mem_size     = f3[1:0];
      dec.mem_unsigned = f3[2];
      case (opcode)
         OP_OP: begin
            dec.rd_wen = 1'b1;
            // Only funct7 0x00 is legal for all funct3; 0x20 only for SUB/SRA.
            if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
               ill = 1'b1;
            case (f3)
               3'b000: dec.alu_mode = f7[5] ? ALU_SUB : ALU_ADD;
               3'b001: dec.alu_mode = ALU_SLL;
               3'b010: begin
                  dec.alu_mode = ALU_SUB; dec.eval_mode = EVAL_LT;
                  dec.sign_ext = 1'b1;    dec.is_slt    = 1'b1;
               end
               3'b011: begin
                  dec.alu_mode = ALU_SUB; dec.eval_mode = EVAL_LT;
                  dec.is_slt   = 1'b1;
               end
               3'b100: dec.alu_mode = ALU_XOR;
               3'b101: dec.alu_mode = f7[5] ? ALU_SRA : ALU_SRL;
               3'b110: dec.alu_mode = ALU_OR;
               default: dec.alu_mode = ALU_AND;
            endcase
         end
         OP_IMM: begin
            dec.rd_wen   = 1'b1;
            dec.src2_imm = 1'b1;
            dec.imm      = imm_i;
            case (f3)
               3'b000: dec.alu_mode = ALU_ADD;
               3'b001: begin
                  dec.alu_mode = ALU_SLL;
                  dec.imm      = {27'b0, in_instr[24:20]};
                  if (f7 != 7'h00) ill = 1'b1;
               end
               3'b010: begin
                  dec.alu_mode = ALU_SUB; dec.eval_mode = EVAL_LT;
                  dec.sign_ext = 1'b1;    dec.is_slt    = 1'b1;
               end
               3'b011: begin
                  dec.alu_mode = ALU_SUB; dec.eval_mode = EVAL_LT;
                  dec.is_slt   = 1'b1;
               end
               3'b100: dec.alu_mode = ALU_XOR;
               3'b101: begin
                  // funct7[5] picks arithmetic shift; any other funct7 bit
                  // (including instr[25], a would-be shamt[5]) is illegal.
                  dec.alu_mode = f7[5] ? ALU_SRA : ALU_SRL;
                  dec.imm      = {27'b0, in_instr[24:20]};
                  if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
               end
               3'b110: dec.alu_mode = ALU_OR;
               default: dec.alu_mode = ALU_AND;
            endcase
         end
         OP_LUI: begin
            dec.rs1_addr = 5'd0;
            dec.src2_imm = 1'b1;
            dec.imm      = imm_u;
            dec.rd_wen   = 1'b1;
         end
         OP_AUIPC: begin
            dec.src1_pc  = 1'b1;
            dec.src2_imm = 1'b1;
            dec.imm      = imm_u;
            dec.rd_wen   = 1'b1;
         end
         OP_JAL: begin
            dec.src1_pc  = 1'b1;
            dec.src2_imm = 1'b1;
            dec.imm      = imm_j;
            dec.rd_wen   = 1'b1;
            dec.is_jal   = 1'b1;
         end
         OP_JALR: begin
            dec.src2_imm = 1'b1;
            dec.imm      = imm_i;
            dec.rd_wen   = 1'b1;
            dec.is_jalr  = 1'b1;
            if (f3 != 3'b000) ill = 1'b1;
         end
         OP_BRANCH: begin
            // The ALU compares rs1-rs2; the target is pc_out+imm, formed by
            // the branch adder downstream, so src1_pc/src2_imm stay 0 here.
            dec.alu_mode  = ALU_SUB;
            dec.is_branch = 1'b1;
            dec.imm       = imm_b;
            case (f3)
               3'b000: dec.eval_mode = EVAL_EQ;
               3'b001: dec.eval_mode = EVAL_NEQ;
               3'b100: begin dec.eval_mode = EVAL_LT; dec.sign_ext = 1'b1; end
               3'b101: begin dec.eval_mode = EVAL_GE; dec.sign_ext = 1'b1; end
               3'b110: dec.eval_mode = EVAL_LT;
               3'b111: dec.eval_mode = EVAL_GE;
               default: ill = 1'b1;
            endcase
         end
         OP_LOAD: begin
            dec.src2_imm = 1'b1;
            dec.imm      = imm_i;
            dec.rd_wen   = 1'b1;
            dec.is_load  = 1'b1;
            if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
         end
         OP_STORE: begin
            dec.src2_imm = 1'b1;
            dec.imm      = imm_s;
            dec.is_store = 1'b1;
            if (f3[2] || f3[1:0] == 2'b11) ill = 1'b1;
         end
         OP_FENCE, OP_SYSTEM: ;
         default: ill = 1'b1;
      endcase

      if (ill) begin
         dec.alu_mode  = ALU_ADD;
         dec.eval_mode = EVAL_EQ;
         dec.sign_ext  = 1'b0;
         dec.rd_wen    = 1'b0;
         dec.src1_pc   = 1'b0;
         dec.src2_imm  = 1'b0;
         dec.is_branch = 1'b0;
         dec.is_jal    = 1'b0;
         dec.is_jalr   = 1'b0;
         dec.is_load   = 1'b0;
         dec.is_store  = 1'b0;
         dec.is_slt    = 1'b0;
      end
      if (dec.rd_addr == 5'd0) dec.rd_wen = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      dec.ill = ill;
`endif
   end

   // Priority: reset, then flush, then transfer, then drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q       <= '0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         q_valid <= 1'b1;
         q       <= dec;
      end else if (out_ready) begin
         q_valid <= 1'b0;
      end
   end

   assign out_valid    = q_valid;
   assign alu_mode     = q.alu_mode;
   assign eval_mode    = q.eval_mode;
   assign sign_ext     = q.sign_ext;
   assign rs1_addr     = q.rs1_addr;
   assign rs2_addr     = q.rs2_addr;
   assign rd_addr      = q.rd_addr;
   assign rd_wen       = q.rd_wen;
   assign imm          = q.imm;
   assign pc_out       = q.pc;
   assign src1_pc      = q.src1_pc;
   assign src2_imm     = q.src2_imm;
   assign is_branch    = q.is_branch;
   assign is_jal       = q.is_jal;
   assign is_jalr      = q.is_jalr;
   assign is_load      = q.is_load;
   assign is_store     = q.is_store;
   assign is_slt       = q.is_slt;
   assign mem_size     = q.mem_size;
   assign mem_unsigned = q.mem_unsigned;
`ifdef DECODE_ILLEGAL_EN
   assign ill_instr    = q.ill;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_SLL = 3'd5, ALU_SRA = 3'd7;
   localparam logic [1:0] EVAL_EQ = 2'd0, EVAL_LT = 2'd2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'h0;
   logic [31:0] in_pc = 32'h0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  alu_mode;
   logic [1:0]  eval_mode;
   logic        sign_ext;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rd_wen;
   logic [31:0] imm, pc_out;
   logic        src1_pc, src2_imm;
   logic        is_branch, is_jal, is_jalr, is_load, is_store, is_slt;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
`ifdef DECODE_ILLEGAL_EN
   logic        ill_instr;
`endif

   int passed = 0;
   int total  = 0;

   decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_mode(alu_mode), .eval_mode(eval_mode), .sign_ext(sign_ext),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_wen(rd_wen),
      .imm(imm), .pc_out(pc_out), .src1_pc(src1_pc), .src2_imm(src2_imm),
      .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
      .is_load(is_load), .is_store(is_store), .is_slt(is_slt),
      .mem_size(mem_size),
`ifdef DECODE_ILLEGAL_EN
      .ill_instr(ill_instr),
`endif
      .mem_unsigned(mem_unsigned)
   );

   // clock
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1ns before sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for exactly one edge (downstream ready).
   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      in_instr = instr;
      in_pc    = pc;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0h exp=0", in_ready); else passed++;
      step(); step();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0h exp=0", out_valid); else passed++;
      total++; if ({alu_mode, eval_mode, rd_wen, imm, pc_out} !== '0)
         $display("FAIL rst_fields got=%0h exp=0", {alu_mode, eval_mode, rd_wen, imm, pc_out}); else passed++;
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got=%0h exp=1", in_ready); else passed++;
   endtask

   task automatic test_addi();
      out_ready = 1'b1;
      push(32'h00500093, 32'h0000_0100);
      total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%0h exp=1", out_valid); else passed++;
      total++; if (alu_mode !== ALU_ADD) $display("FAIL addi_alu got=%0h exp=%0h", alu_mode, ALU_ADD); else passed++;
      total++; if (src2_imm !== 1'b1) $display("FAIL addi_src2 got=%0h exp=1", src2_imm); else passed++;
      total++; if (imm !== 32'd5) $display("FAIL addi_imm got=%0h exp=5", imm); else passed++;
      total++; if (rd_addr !== 5'd1 || rd_wen !== 1'b1)
         $display("FAIL addi_rd got=%0h/%0h exp=1/1", rd_addr, rd_wen); else passed++;
      total++; if (pc_out !== 32'h100) $display("FAIL addi_pc got=%0h exp=100", pc_out); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got=%0h exp=0", out_valid); else passed++;
   endtask

   task automatic test_bltu();
      push(32'hFE20EEE3, 32'h0000_0200);
      total++; if (alu_mode !== ALU_SUB || eval_mode !== EVAL_LT || sign_ext !== 1'b0)
         $display("FAIL bltu_ctl got=%0h/%0h/%0h exp=1/2/0", alu_mode, eval_mode, sign_ext); else passed++;
      total++; if (is_branch !== 1'b1 || rd_wen !== 1'b0)
         $display("FAIL bltu_flags got=%0h/%0h exp=1/0", is_branch, rd_wen); else passed++;
      total++; if (imm !== 32'hFFFF_FFFC) $display("FAIL bltu_imm got=%0h exp=fffffffc", imm); else passed++;
      total++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2)
         $display("FAIL bltu_rs got=%0h/%0h exp=1/2", rs1_addr, rs2_addr); else passed++;
   endtask

   task automatic test_alu_ops();
      push(32'h4041D193, 32'h0000_0300);   // SRAI x3,x3,4
      total++; if (alu_mode !== ALU_SRA || imm[4:0] !== 5'd4)
         $display("FAIL srai got=%0h/%0h exp=7/4", alu_mode, imm[4:0]); else passed++;
      push(32'h007332B3, 32'h0000_0304);   // SLTU x5,x6,x7
      total++; if (alu_mode !== ALU_SUB || eval_mode !== EVAL_LT || sign_ext !== 1'b0 || is_slt !== 1'b1)
         $display("FAIL sltu got=%0h/%0h/%0h/%0h exp=1/2/0/1", alu_mode, eval_mode, sign_ext, is_slt); else passed++;
      push(32'h0020A1B3, 32'h0000_0308);   // SLT x3,x1,x2
      total++; if (sign_ext !== 1'b1 || is_slt !== 1'b1 || rd_wen !== 1'b1)
         $display("FAIL slt got=%0h/%0h/%0h exp=1/1/1", sign_ext, is_slt, rd_wen); else passed++;
      push(32'h00209093, 32'h0000_030C);   // SLLI x1,x1,2
      total++; if (alu_mode !== ALU_SLL || imm !== 32'd2)
         $display("FAIL slli got=%0h/%0h exp=5/2", alu_mode, imm); else passed++;
      push(32'h123450B7, 32'h0000_0310);   // LUI x1,0x12345
      total++; if (imm !== 32'h1234_5000 || rs1_addr !== 5'd0 || src2_imm !== 1'b1 || src1_pc !== 1'b0)
         $display("FAIL lui got=%0h/%0h/%0h exp=12345000/0/1", imm, rs1_addr, src2_imm); else passed++;
      push(32'h008000EF, 32'h0000_0314);   // JAL x1,+8
      total++; if (imm !== 32'd8 || is_jal !== 1'b1 || src1_pc !== 1'b1 || rd_wen !== 1'b1)
         $display("FAIL jal got=%0h/%0h/%0h exp=8/1/1", imm, is_jal, src1_pc); else passed++;
      push(32'h0020A223, 32'h0000_0318);   // SW x2,4(x1)
      total++; if (imm !== 32'd4 || is_store !== 1'b1 || rd_wen !== 1'b0 || mem_size !== 2'd2)
         $display("FAIL sw got=%0h/%0h/%0h/%0h exp=4/1/0/2", imm, is_store, rd_wen, mem_size); else passed++;
      push(32'hFFC14083, 32'h0000_031C);   // LBU x1,-4(x2)
      total++; if (imm !== 32'hFFFF_FFFC || is_load !== 1'b1 || mem_unsigned !== 1'b1 || mem_size !== 2'd0)
         $display("FAIL lbu got=%0h/%0h/%0h exp=fffffffc/1/1", imm, is_load, mem_unsigned); else passed++;
      push(32'h00100013, 32'h0000_0320);   // ADDI x0,x0,1
      total++; if (rd_wen !== 1'b0) $display("FAIL rd0_wen got=%0h exp=0", rd_wen); else passed++;
      push(32'h00000073, 32'h0000_0324);   // ECALL -> NOP
      total++; if (alu_mode !== ALU_ADD || eval_mode !== EVAL_EQ || rd_wen !== 1'b0 || is_branch !== 1'b0)
         $display("FAIL ecall_nop got=%0h/%0h/%0h exp=0/0/0", alu_mode, eval_mode, rd_wen); else passed++;
      step();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      push(32'h00500093, 32'h0000_0400);   // A: ADDI x1,x0,5
      in_instr = 32'h00A00113;             // B: ADDI x2,x0,10
      in_pc    = 32'h0000_0404;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (in_ready !== 1'b0) $display("FAIL stall_ready c%0d got=%0h exp=0", i, in_ready); else passed++;
         total++; if (out_valid !== 1'b1 || pc_out !== 32'h400 || imm !== 32'd5)
            $display("FAIL stall_hold c%0d got=%0h/%0h/%0h exp=1/400/5", i, out_valid, pc_out, imm); else passed++;
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL release_ready got=%0h exp=1", in_ready); else passed++;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || pc_out !== 32'h404 || imm !== 32'd10 || rd_addr !== 5'd2)
         $display("FAIL release_b got=%0h/%0h/%0h exp=1/404/a", out_valid, pc_out, imm); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL release_nodup got=%0h exp=0", out_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_instr = 32'h00000093 | (32'(i + 1) << 20);   // ADDI x1,x0,i+1
         in_pc    = 32'h500 + 32'(4 * i);
         step();
         total++; if (out_valid !== 1'b1 || pc_out !== 32'h500 + 32'(4 * i) || imm !== 32'(i + 1))
            $display("FAIL b2b_%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, out_valid, pc_out, imm,
                     32'h500 + 32'(4 * i), i + 1); else passed++;
      end
      in_valid = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%0h exp=0", out_valid); else passed++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      push(32'h00500093, 32'h0000_0600);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h00A00113;
      in_pc    = 32'h0000_0604;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%0h exp=0", out_valid); else passed++;
      out_ready = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL flush_discard got=%0h exp=0", out_valid); else passed++;
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      push(32'hFE20EEE3, 32'h0000_0700);
      total++; if (out_valid !== 1'b1) $display("FAIL mid_pre got=%0h exp=1", out_valid); else passed++;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h00500093;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got=%0h exp=0", in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL mid_valid got=%0h exp=0", out_valid); else passed++;
      total++; if ({alu_mode, eval_mode, is_branch, imm, pc_out, rs1_addr, rs2_addr} !== '0)
         $display("FAIL mid_zero got=%0h exp=0", {alu_mode, eval_mode, is_branch, imm, pc_out}); else passed++;
      rst      = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
   endtask

`ifdef DECODE_ILLEGAL_EN
   task automatic test_illegal();
      out_ready = 1'b1;
      push(32'hFFFFFFFF, 32'h0000_0800);
      total++; if (ill_instr !== 1'b1 || rd_wen !== 1'b0)
         $display("FAIL ill_ones got=%0h/%0h exp=1/0", ill_instr, rd_wen); else passed++;
      push(32'h0240D093, 32'h0000_0804);   // SRLI with instr[25]=1
      total++; if (ill_instr !== 1'b1 || rd_wen !== 1'b0)
         $display("FAIL ill_shamt got=%0h/%0h exp=1/0", ill_instr, rd_wen); else passed++;
      push(32'h00500093, 32'h0000_0808);
      total++; if (ill_instr !== 1'b0 || rd_wen !== 1'b1)
         $display("FAIL ill_legal got=%0h/%0h exp=0/1", ill_instr, rd_wen); else passed++;
      step();
   endtask
`else
   task automatic test_illegal();
      out_ready = 1'b1;
      push(32'hFFFFFFFF, 32'h0000_0800);
      total++; if (rd_wen !== 1'b0 || alu_mode !== ALU_ADD || is_branch !== 1'b0 || is_jal !== 1'b0)
         $display("FAIL ill_nop got=%0h/%0h exp=0/0", rd_wen, alu_mode); else passed++;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_addi();
      test_bltu();
      test_alu_ops();
      test_stall();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      test_illegal();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
